text_console: RTL and testbench
===============================

# text_console

Byte-stream text writer for the 80x25 text buffer scanned by the video output block. Accepts one ASCII/control byte per handshake. Writes character/attribute pairs into video memory at 16'h8000 + 2*cell. Handles CR, LF, BS, form-feed clear and end-of-screen scroll, and drives the 12-bit hardware cursor index consumed by the video block.

## Interface
- COLS, 80, characters per row
- ROWS, 25, rows per screen
- BASE, 16'h8000, byte address of cell 0 (char at even address, attr at odd)
- clock  in  1  system clock (video pixel clock domain)
- reset  in  1  one clock; reset is synchronous and active-high
- in_data  in  8  byte to print or control code
- in_attr  in  8  attribute for this byte, sampled with in_data
- in_valid  in  1  byte offered
- in_ready  out  1  block idle, byte accepted on clock edge with in_valid=1
- mem_a  out  16  video RAM write-port address
- mem_d  out  8  write data
- mem_we  out  1  write strobe
- mem_q  in  8  read data, valid one cycle after mem_a (synchronous RAM)
- cursor  out  12  cell index row*COLS+col, 0..1999

## Operation
- States: IDLE, PUT_C, PUT_A, SCROLL_RD, SCROLL_WR, CLR_LINE, CLR_ALL.
- IDLE: in_ready=1. On in_valid, latch byte and attr, then decode:
  - 0x0D CR: col=0, stay IDLE.
  - 0x0A LF: if row<24, row+1. Otherwise do the end-of-screen action.
  - 0x08 BS: col-1 if col>0, else no change. Nothing is erased.
  - 0x0C FF: go CLR_ALL.
  - Any other byte: go PUT_C.
- PUT_C writes the char at BASE+2*cursor. PUT_A writes the attr at BASE+2*cursor+1. Then col+1.
- If col reaches 80: col=0 and apply the LF rule.
- End-of-screen action with the scroll feature compiled in: row stays 24 and the block goes SCROLL_RD.
- SCROLL_RD/SCROLL_WR loop over byte offset i=0..3839:
  - SCROLL_RD: mem_a=BASE+160+i.
  - SCROLL_WR: mem_a=BASE+i, mem_d=mem_q, we=1.
- CLR_LINE then writes 160 bytes from BASE+3840, one per cycle. Even bytes get 0x20, odd bytes get the latched attr.
- CLR_ALL writes 4000 bytes from BASE the same way, then sets the cursor to 0.
- cursor = row*80+col is registered and updates on the cycle the state returns to IDLE or enters a scroll/clear state.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_a=0, mem_d=0, cursor=0, state IDLE, row=col=0.
- Reset does not clear memory.
- Reset mid-operation aborts on the next edge and mem_we=0 immediately. A partially scrolled screen is left as is.
- Printable byte: accepted at edge 0, PUT_C at cycle 1, PUT_A at cycle 2, in_ready=1 at cycle 3.
- CR, LF without scroll, and BS: in_ready stays 1, so back-to-back acceptance is allowed every cycle.
- Scroll: 7680 copy cycles plus 160 clear cycles. It starts the cycle after PUT_A or after LF acceptance.
- FF: 4000 cycles, in_ready=0 throughout.
- in_ready is 0 in every state other than IDLE. in_data is ignored while in_ready=0.
- Only one memory access per cycle. mem_we is never asserted in SCROLL_RD.
- Arithmetic: row 5 bits, col 7 bits, copy/clear counter 12 bits. Addresses are BASE plus the zero-extended offset, with no wrap beyond 16 bits.

## Configuration
- TEXT_CONSOLE_SCROLL_EN defined: end-of-screen action is scroll plus clearing the last line, as above.
- Not defined: end-of-screen action sets row=0, keeps col, and returns to IDLE. No memory is copied or cleared. SCROLL_* and CLR_LINE are not synthesized.

## Structure
- Package console_pkg holds:
  - COLS, ROWS, BASE and cell/byte counts (2000, 4000, 3840, 160).
  - Control-code constants CC_CR, CC_LF, CC_BS, CC_FF.
  - The state enum.
- One sub-module, console_cursor, holds row/col counters, the CR/LF/BS/advance commands, the end-of-screen flag and the registered cursor index.

## Test plan
- Reset, then 'A' with attr 0x1F: expect writes 0x8000<=0x41 and 0x8001<=0x1F, then cursor=1 and in_ready=1 at cycle 3.
- Send 80 printable bytes from cursor 0: expect the last write at 0x809E/0x809F, then cursor=80. CR then gives cursor=80; BS at col 0 leaves cursor=80.
- Preload the row 1 char at 0x80A0=0x42. With cursor at 1920, send LF (scroll build): expect 0x8000=0x42 after the copy and 0x8F00..0x8F9F cleared to 0x20/attr. Expect cursor=1920 and in_ready low for exactly 7840 cycles.
- Same stimulus in a build without the macro: expect cursor=0, no mem_we, and in_ready continuously high.
- FF with attr 0x07: expect 4000 writes alternating 0x20/0x07 over 0x8000..0x8F9F, then cursor=0.
- Assert reset mid-scroll: expect mem_we=0 on the next cycle, then cursor=0 and in_ready=1.

Source files
------------

// File: rtl/console_pkg.sv
// ============================================================================
//  Module      : console_pkg
//  Description : Shared geometry, control codes and FSM state encoding for
//                the text_console byte-stream writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package console_pkg;

    localparam int          COLS         = 80;
    localparam int          ROWS         = 25;
    localparam logic [15:0] BASE         = 16'h8000;

    localparam int          CELLS        = 2000;
    localparam int          SCREEN_BYTES = 4000;
    localparam int          SCROLL_BYTES = 3840;
    localparam int          LINE_BYTES   = 160;

    localparam logic [7:0]  CC_CR        = 8'h0D;
    localparam logic [7:0]  CC_LF        = 8'h0A;
    localparam logic [7:0]  CC_BS        = 8'h08;
    localparam logic [7:0]  CC_FF        = 8'h0C;
    localparam logic [7:0]  CHAR_SPACE   = 8'h20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUT_C     = 3'd1,
        PUT_A     = 3'd2,
        SCROLL_RD = 3'd3,
        SCROLL_WR = 3'd4,
        CLR_LINE  = 3'd5,
        CLR_ALL   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/console_cursor.sv
// ============================================================================
//  Module      : console_cursor
//  Description : Row/column tracker with CR/LF/BS/advance/home commands and a
//                registered linear cursor index. Macro: TEXT_CONSOLE_SCROLL_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module console_cursor
    import console_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_cr,
    input  logic        cmd_lf,
    input  logic        cmd_bs,
    input  logic        cmd_adv,
    input  logic        cmd_home,
    output logic        lf_eos,
    output logic        adv_eos,
    output logic [11:0] cursor
);

    localparam logic [4:0] c_LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] c_LAST_COL = 7'(COLS - 1);

    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [11:0] r_cursor;
    logic [4:0]  w_row_n;
    logic [6:0]  w_col_n;
    logic [4:0]  w_row_lf;

    // Row after a line feed; at the bottom the scroll build keeps the last
    // row (the screen content moves instead), otherwise it wraps to the top.
    always_comb begin
        w_row_lf = r_row + 5'd1;
        if (r_row == c_LAST_ROW) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
            w_row_lf = r_row;
`else
            w_row_lf = 5'd0;
`endif
        end
    end

    always_comb begin
        w_row_n = r_row;
        w_col_n = r_col;
        if (cmd_home) begin
            w_row_n = 5'd0;
            w_col_n = 7'd0;
        end else if (cmd_cr) begin
            w_col_n = 7'd0;
        end else if (cmd_lf) begin
            w_row_n = w_row_lf;
        end else if (cmd_bs) begin
            if (r_col != 7'd0) begin
                w_col_n = r_col - 7'd1;
            end
        end else if (cmd_adv) begin
            if (r_col == c_LAST_COL) begin
                w_col_n = 7'd0;
                w_row_n = w_row_lf;
            end else begin
                w_col_n = r_col + 7'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_row    <= 5'd0;
            r_col    <= 7'd0;
            r_cursor <= 12'd0;
        end else begin
            r_row    <= w_row_n;
            r_col    <= w_col_n;
            r_cursor <= 12'(w_row_n) * 12'(COLS) + 12'(w_col_n);
        end
    end

    assign lf_eos  = (r_row == c_LAST_ROW);
    assign adv_eos = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
    assign cursor  = r_cursor;

endmodule

`default_nettype wire

// File: rtl/text_console.sv
// ============================================================================
//  Module      : text_console
//  Description : Byte-stream writer into the 80x25 video text buffer with
//                CR/LF/BS/FF handling. Macro: TEXT_CONSOLE_SCROLL_EN enables
//                end-of-screen scroll plus last-line clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_console
    import console_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_attr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_d,
    output logic        mem_we,
    input  logic [7:0]  mem_q,
    output logic [11:0] cursor
);

    state_e      r_state;
    logic        r_in_ready;
    logic        r_mem_we;
    logic [15:0] r_mem_a;
    logic [7:0]  r_mem_d;
    logic [7:0]  r_attr;
    logic [11:0] r_cnt;

    logic        w_accept;
    logic        w_cmd_cr;
    logic        w_cmd_lf;
    logic        w_cmd_bs;
    logic        w_cmd_adv;
    logic        w_cmd_home;
    logic        w_lf_eos;
    logic        w_adv_eos;
    logic [11:0] w_cursor;

    assign w_accept   = in_valid && r_in_ready;
    assign w_cmd_cr   = w_accept && (in_data == CC_CR);
    assign w_cmd_lf   = w_accept && (in_data == CC_LF);
    assign w_cmd_bs   = w_accept && (in_data == CC_BS);
    assign w_cmd_adv  = (r_state == PUT_A);
    assign w_cmd_home = (r_state == CLR_ALL) && (r_cnt == 12'(SCREEN_BYTES - 1));

    console_cursor u_cursor (
        .clock    (clock),
        .reset    (reset),
        .cmd_cr   (w_cmd_cr),
        .cmd_lf   (w_cmd_lf),
        .cmd_bs   (w_cmd_bs),
        .cmd_adv  (w_cmd_adv),
        .cmd_home (w_cmd_home),
        .lf_eos   (w_lf_eos),
        .adv_eos  (w_adv_eos),
        .cursor   (w_cursor)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_a    <= 16'd0;
            r_mem_d    <= 8'd0;
            r_attr     <= 8'd0;
            r_cnt      <= 12'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_attr <= in_attr;
                        if (in_data == CC_FF) begin
                            r_state    <= CLR_ALL;
                            r_in_ready <= 1'b0;
                            r_cnt      <= 12'd0;
                            r_mem_a    <= BASE;
                            r_mem_d    <= CHAR_SPACE;
                            r_mem_we   <= 1'b1;
                        end else if (in_data == CC_LF) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                            if (w_lf_eos) begin
                                r_state    <= SCROLL_RD;
                                r_in_ready <= 1'b0;
                                r_cnt      <= 12'd0;
                                r_mem_a    <= BASE + 16'(LINE_BYTES);
                                r_mem_we   <= 1'b0;
                            end
`endif
                        end else if ((in_data != CC_CR) && (in_data != CC_BS)) begin
                            r_state    <= PUT_C;
                            r_in_ready <= 1'b0;
                            r_mem_a    <= BASE + {3'd0, w_cursor, 1'b0};
                            r_mem_d    <= in_data;
                            r_mem_we   <= 1'b1;
                        end
                    end
                end

                PUT_C: begin
                    r_state <= PUT_A;
                    r_mem_a <= r_mem_a + 16'd1;
                    r_mem_d <= r_attr;
                end

                PUT_A: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_mem_we   <= 1'b0;
`ifdef TEXT_CONSOLE_SCROLL_EN
                    if (w_adv_eos) begin
                        r_state    <= SCROLL_RD;
                        r_in_ready <= 1'b0;
                        r_cnt      <= 12'd0;
                        r_mem_a    <= BASE + 16'(LINE_BYTES);
                    end
`endif
                end

`ifdef TEXT_CONSOLE_SCROLL_EN
                // Copy loop: read the byte one row below, then write it back
                // one row up using the RAM output captured during the read.
                SCROLL_RD: begin
                    r_state  <= SCROLL_WR;
                    r_mem_a  <= BASE + {4'd0, r_cnt};
                    r_mem_we <= 1'b1;
                end

                SCROLL_WR: begin
                    if (r_cnt == 12'(SCROLL_BYTES - 1)) begin
                        r_state  <= CLR_LINE;
                        r_cnt    <= 12'd0;
                        r_mem_a  <= BASE + 16'(SCROLL_BYTES);
                        r_mem_d  <= CHAR_SPACE;
                        r_mem_we <= 1'b1;
                    end else begin
                        r_state  <= SCROLL_RD;
                        r_cnt    <= r_cnt + 12'd1;
                        r_mem_a  <= BASE + 16'(LINE_BYTES) + {4'd0, r_cnt + 12'd1};
                        r_mem_we <= 1'b0;
                    end
                end

                CLR_LINE: begin
                    if (r_cnt == 12'(LINE_BYTES - 1)) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_mem_we   <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 12'd1;
                        r_mem_a <= r_mem_a + 16'd1;
                        r_mem_d <= r_cnt[0] ? CHAR_SPACE : r_attr;
                    end
                end
`endif

                CLR_ALL: begin
                    if (r_cnt == 12'(SCREEN_BYTES - 1)) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_mem_we   <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 12'd1;
                        r_mem_a <= r_mem_a + 16'd1;
                        r_mem_d <= r_cnt[0] ? CHAR_SPACE : r_attr;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_mem_we   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TEXT_CONSOLE_SCROLL_EN
    assign mem_d = (r_state == SCROLL_WR) ? mem_q : r_mem_d;
`else
    logic w_unused_sink;
    assign w_unused_sink = ^{mem_q, w_lf_eos, w_adv_eos};
    assign mem_d         = r_mem_d;
`endif

    assign in_ready = r_in_ready;
    assign mem_a    = r_mem_a;
    assign mem_we   = r_mem_we;
    assign cursor   = w_cursor;

endmodule

`default_nettype wire

// File: tb/tb_text_console.sv
// ============================================================================
//  Module      : tb_text_console
//  Description : Scoreboard bench for text_console; follows the build setting
//                of TEXT_CONSOLE_SCROLL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_console;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic [7:0]  in_attr = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mem_a;
    logic [7:0]  mem_d;
    logic        mem_we;
    logic [7:0]  mem_q;
    logic [11:0] cursor;

    logic [7:0]  mem [0:65535];
    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b1;

    text_console dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_attr  (in_attr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .mem_we   (mem_we),
        .mem_q    (mem_q),
        .cursor   (cursor)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_a] <= mem_d;
        mem_q <= mem[mem_a];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every write the DUT performs must match the next expected write.
    always @(negedge clock) begin
        if (mon_en && !reset && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_a, mem_d);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {16'd0, mem_a}, {16'd0, e.a});
                chk("wr_data", {24'd0, mem_d}, {24'd0, e.d});
            end
        end
    end

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        @(negedge clock);
        in_data  = d;
        in_attr  = a;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles with in_ready low after an accept; stops at a ready cycle.
    task automatic wait_idle(input int limit, output int n);
        n = 0;
        @(negedge clock);
        while (!in_ready && n < limit) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_cur;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);

        repeat (3) @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("rst_mem_a",    {16'd0, mem_a},    32'd0);
        chk("rst_mem_d",    {24'd0, mem_d},    32'd0);
        chk("rst_cursor",   {20'd0, cursor},   32'd0);
        reset = 1'b0;

        expect_wr(16'h8000, 8'h41);
        expect_wr(16'h8001, 8'h1F);
        send(8'h41, 8'h1F);
        wait_idle(20, n);
        chk("A_busy_cycles", n, 2);
        chk("A_cursor", {20'd0, cursor}, 32'd1);

        send(8'h0D, 8'h00);
        wait_idle(20, n);
        chk("cr_busy_cycles", n, 0);
        chk("cr_cursor", {20'd0, cursor}, 32'd0);

        for (int i = 0; i < 80; i++) begin
            expect_wr(16'(16'h8000 + 2 * i), 8'(8'h30 + i % 10));
            expect_wr(16'(16'h8001 + 2 * i), 8'h1F);
            send(8'(8'h30 + i % 10), 8'h1F);
            wait_idle(20, n);
        end
        chk("row0_cursor", {20'd0, cursor}, 32'd80);
        chk("row0_drained", exp_q.size(), 0);

        send(8'h0D, 8'h00);
        wait_idle(20, n);
        chk("cr_col0_cursor", {20'd0, cursor}, 32'd80);
        send(8'h08, 8'h00);
        wait_idle(20, n);
        chk("bs_col0_cursor", {20'd0, cursor}, 32'd80);

        expect_wr(16'h80A0, 8'h78);
        expect_wr(16'h80A1, 8'h1F);
        send(8'h78, 8'h1F);
        wait_idle(20, n);
        chk("x_cursor", {20'd0, cursor}, 32'd81);
        send(8'h08, 8'h00);
        wait_idle(20, n);
        chk("bs_cursor", {20'd0, cursor}, 32'd80);

        // CR then LF on consecutive edges
        @(negedge clock);
        in_data  = 8'h0D;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_data  = 8'h0A;
        @(negedge clock);
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("b2b_cursor", {20'd0, cursor}, 32'd160);

        for (int i = 0; i < 22; i++) begin
            send(8'h0A, 8'h00);
            wait_idle(20, n);
        end
        chk("bottom_cursor", {20'd0, cursor}, 32'd1920);

        mem[16'h80A0] = 8'h42;
`ifdef TEXT_CONSOLE_SCROLL_EN
        for (int i = 0; i < 3840; i++) expect_wr(16'(16'h8000 + i), mem[16'(16'h80A0 + i)]);
        for (int j = 0; j < 160; j++) expect_wr(16'(16'h8F00 + j), (j % 2 == 1) ? 8'h2E : 8'h20);
        send(8'h0A, 8'h2E);
        wait_idle(9000, n);
        chk("scroll_busy_cycles", n, 7840);
        chk("scroll_cursor", {20'd0, cursor}, 32'd1920);
        chk("scroll_row1_moved", {24'd0, mem[16'h8000]}, 32'h42);
        chk("scroll_clr_char", {24'd0, mem[16'h8F00]}, 32'h20);
        chk("scroll_clr_attr", {24'd0, mem[16'h8F9F]}, 32'h2E);
        base_cur = 1920;
`else
        send(8'h0A, 8'h2E);
        wait_idle(9000, n);
        chk("wrap_busy_cycles", n, 0);
        chk("wrap_cursor", {20'd0, cursor}, 32'd0);
        chk("wrap_no_copy", {24'd0, mem[16'h8000]}, 32'h30);
        base_cur = 0;
`endif

        expect_wr(16'(16'h8000 + 2 * base_cur), 8'h42);
        expect_wr(16'(16'h8001 + 2 * base_cur), 8'h1F);
        send(8'h42, 8'h1F);
        wait_idle(20, n);
        chk("B_cursor", {20'd0, cursor}, 32'(base_cur + 1));

        for (int i = 0; i < 4000; i++) expect_wr(16'(16'h8000 + i), (i % 2 == 1) ? 8'h07 : 8'h20);
        send(8'h0C, 8'h07);
        wait_idle(9000, n);
        chk("ff_busy_cycles", n, 4000);
        chk("ff_cursor", {20'd0, cursor}, 32'd0);
        chk("ff_drained", exp_q.size(), 0);

        mon_en = 1'b0;
`ifdef TEXT_CONSOLE_SCROLL_EN
        for (int i = 0; i < 24; i++) begin
            send(8'h0A, 8'h00);
            wait_idle(20, n);
        end
        send(8'h0A, 8'h00);
`else
        send(8'h0C, 8'h00);
`endif
        repeat (101) @(negedge clock);
        chk("midop_busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_cursor", {20'd0, cursor}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;

        expect_wr(16'h8000, 8'h43);
        expect_wr(16'h8001, 8'h1F);
        send(8'h43, 8'h1F);
        wait_idle(20, n);
        chk("post_abort_cursor", {20'd0, cursor}, 32'd1);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
